// File: rtl/latch_write_sched_if.sv
// Bundles the requester handshake and the latch-bank drive signals of latch_write_sched.
// The master side belongs to the requesters and the latch bank; the slave side belongs to the scheduler.
interface latch_write_sched_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NLATCH = 4,
  parameter int unsigned AW     = $clog2(NLATCH)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [NLATCH-1:0]     lat_en;
  logic [WIDTH-1:0]      lat_d;
  logic                  busy;

  modport master (
    output req, req_addr, req_data,
    input  ack, err, lat_en, lat_d, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, err, lat_en, lat_d, busy
  );
endinterface

// File: rtl/latch_write_sched.sv
// Round-robin write sequencer for a bank of level-sensitive latches sharing one D bus.
// Each write runs SETUP -> OPEN -> HOLD so that D is stable around the whole EN pulse.
module latch_write_sched #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned NLATCH   = 4,
  parameter int unsigned OPEN_CYC = 2
) (
  input logic                clk,
  input logic                reset,
  latch_write_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(NLATCH);
  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StOpen, StHold} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NLATCH-1:0] lat_en_q, lat_en_d;
  logic [WIDTH-1:0]  lat_d_q, lat_d_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     idx;

  // Out-of-range addresses decode to no enable at all.
  function automatic logic [NLATCH-1:0] en_decode(input logic [AW-1:0] a);
    logic [NLATCH-1:0] en;
    en = '0;
    for (int unsigned i = 0; i < NLATCH; i++) begin
      en[i] = (32'(a) == i);
    end
    return en;
  endfunction

  // Search starts just after the last grant, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    lat_en_d = '0;
    lat_d_d  = lat_d_q;
    ack_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StSetup;
          ptr_d   = pick;
          gnt_d   = pick;
          addr_d  = bus.req_addr[pick*AW +: AW];
          data_d  = bus.req_data[pick*WIDTH +: WIDTH];
          // D is driven from the grant edge so it settles a full cycle before EN.
          lat_d_d = bus.req_data[pick*WIDTH +: WIDTH];
        end
      end
      StSetup: begin
        state_d  = StOpen;
        cnt_d    = CW'(OPEN_CYC - 1);
        lat_en_d = en_decode(addr_q);
        lat_d_d  = data_q;
      end
      StOpen: begin
        lat_d_d = data_q;
        if (cnt_q == '0) begin
          state_d       = StHold;
          ack_d[gnt_q]  = 1'b1;
          err_d         = (32'(addr_q) >= NLATCH);
        end else begin
          cnt_d    = cnt_q - CW'(1);
          lat_en_d = en_decode(addr_q);
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Asynchronous reset drops every enable at once so no latch stays transparent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= PW'(NREQ - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      lat_en_q <= '0;
      lat_d_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      lat_en_q <= lat_en_d;
      lat_d_q  <= lat_d_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.lat_en = lat_en_q;
  assign bus.lat_d  = lat_d_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != StIdle);

endmodule
